// File: rtl/dma_cfg_seq.sv
// DMA programming master: queued descriptors become SRC/DST/LEN/START writes.
// Define DMA_CFG_SEQ_BRESP_CHECK_EN to abort a descriptor on a non-OKAY write response.
module dma_cfg_seq #(
    parameter int          NUM_CH     = 4,
    parameter int          DESC_DEPTH = 4,
    parameter logic [31:0] CH_STRIDE  = 32'h200,
    localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CH_W+95:0]  i_desc_msg,
    input  logic              i_desc_val,
    output logic              o_desc_rdy,
    output logic [43:0]       o_aw_msg,
    output logic              o_aw_val,
    input  logic              i_aw_rdy,
    output logic [72:0]       o_w_msg,
    output logic              o_w_val,
    input  logic              i_w_rdy,
    input  logic [5:0]        i_b_msg,
    input  logic              i_b_val,
    output logic              o_b_rdy,
    input  logic [CH_W-1:0]   i_done_msg,
    input  logic              i_done_val,
    output logic              o_done_rdy,
    output logic [NUM_CH-1:0] o_busy,
    output logic [15:0]       o_done_cnt,
    output logic [7:0]        o_err_cnt
);
    localparam int          PW  = $clog2(DESC_DEPTH);
    localparam int          NX  = 1 << CH_W;
    localparam logic [CH_W:0] NCH = NUM_CH[CH_W:0];

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    logic [CH_W+95:0] r_mem [DESC_DEPTH];
    logic [PW:0]      r_wp, r_rp;
    state_t           r_state, w_state_nx;
    logic [1:0]       r_idx, w_idx_nx;
    logic [CH_W-1:0]  r_ch, w_ch_nx;
    logic [31:0]      r_src, r_dst, r_len;
    logic             r_aw_val, r_w_val, r_b_rdy;
    logic [43:0]      r_aw_msg;
    logic [72:0]      r_w_msg;
    logic [NUM_CH-1:0] r_busy, w_busy_nx;
    logic [15:0]      r_done_cnt;
    logic [7:0]       r_err_cnt;

    logic             w_empty, w_full, w_push, w_pop, w_load;
    logic [CH_W+95:0] w_head;
    logic [CH_W-1:0]  w_head_ch;
    logic             w_head_ok;
    logic [NX-1:0]    w_busy_x;
    logic             w_drop_len0, w_drop_bad, w_set, w_resp_err, w_resp_bad;
    logic             w_done_hit, w_done_spur;
    logic [31:0]      w_addr, w_data;
    logic [1:0]       w_err_inc;
    logic [8:0]       w_err_sum;
    logic             w_unused;

    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
    assign w_push    = i_desc_val && o_desc_rdy;
    assign w_head    = r_mem[r_rp[PW-1:0]];
    assign w_head_ch = w_head[CH_W+95:96];
    assign w_head_ok = {1'b0, w_head_ch} < NCH;
    assign w_unused  = ^i_b_msg;

`ifdef DMA_CFG_SEQ_BRESP_CHECK_EN
    assign w_resp_bad = |i_b_msg[1:0];
`else
    assign w_resp_bad = 1'b0;
`endif

    always_comb begin
        w_busy_x = '0;
        w_busy_x[NUM_CH-1:0] = r_busy;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_ch_nx     = r_ch;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_drop_len0 = 1'b0;
        w_drop_bad  = 1'b0;
        w_set       = 1'b0;
        w_resp_err  = 1'b0;
        unique case (r_state)
            S_IDLE: if (!w_empty) begin
                if (!w_head_ok) begin
                    w_pop      = 1'b1;
                    w_drop_bad = 1'b1;
                end else if (w_head[95:64] == 32'd0) begin
                    w_pop       = 1'b1;
                    w_drop_len0 = 1'b1;
                end else if (!w_busy_x[w_head_ch]) begin
                    w_pop      = 1'b1;
                    w_load     = 1'b1;
                    w_ch_nx    = w_head_ch;
                    w_idx_nx   = 2'd0;
                    w_state_nx = S_AW;
                end
            end
            S_AW: if (i_aw_rdy) w_state_nx = S_W;
            S_W:  if (i_w_rdy) w_state_nx = S_B;
            S_B: if (i_b_val) begin
                if (w_resp_bad) begin
                    w_resp_err = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (r_idx != 2'd3) begin
                    w_idx_nx   = r_idx + 2'd1;
                    w_state_nx = S_AW;
                end else begin
                    w_set      = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Address is formed from next-state index so it is ready with aw_val.
    assign w_addr = 32'(w_ch_nx) * CH_STRIDE + {23'd0, w_idx_nx, 7'd0};

    always_comb begin
        unique case (r_idx)
            2'd0:    w_data = r_src;
            2'd1:    w_data = r_dst;
            2'd2:    w_data = r_len;
            default: w_data = 32'd1;
        endcase
    end

    assign w_done_hit  = i_done_val && w_busy_x[i_done_msg];
    assign w_done_spur = i_done_val && !w_busy_x[i_done_msg];

    // Clear applied before set, so a same-cycle START on the channel wins.
    always_comb begin
        w_busy_nx = r_busy;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_done_hit && i_done_msg == CH_W'(c)) w_busy_nx[c] = 1'b0;
            if (w_set && r_ch == CH_W'(c)) w_busy_nx[c] = 1'b1;
        end
    end

    assign w_err_inc = {1'b0, w_drop_bad} + {1'b0, w_resp_err} + {1'b0, w_done_spur};
    assign w_err_sum = {1'b0, r_err_cnt} + {7'd0, w_err_inc};

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp[PW-1:0]] <= i_desc_msg;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_ch       <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_aw_val   <= 1'b0;
            r_w_val    <= 1'b0;
            r_b_rdy    <= 1'b0;
            r_aw_msg   <= '0;
            r_w_msg    <= '0;
            r_busy     <= '0;
            r_done_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_load) begin
                r_src <= w_head[31:0];
                r_dst <= w_head[63:32];
                r_len <= w_head[95:64];
            end
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_ch       <= w_ch_nx;
            r_aw_val   <= (w_state_nx == S_AW);
            r_w_val    <= (w_state_nx == S_W);
            r_b_rdy    <= (w_state_nx == S_B);
            r_aw_msg   <= (w_state_nx == S_AW) ? {12'd0, w_addr} : '0;
            r_w_msg    <= (w_state_nx == S_W) ? {8'hFF, 1'b1, 32'd0, w_data} : '0;
            r_busy     <= w_busy_nx;
            r_done_cnt <= r_done_cnt + {15'd0, w_drop_len0} + {15'd0, w_done_hit};
            r_err_cnt  <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign o_desc_rdy = !w_full && !i_rst;
    assign o_aw_val   = r_aw_val;
    assign o_aw_msg   = r_aw_msg;
    assign o_w_val    = r_w_val;
    assign o_w_msg    = r_w_msg;
    assign o_b_rdy    = r_b_rdy;
    assign o_done_rdy = 1'b1;
    assign o_busy     = r_busy;
    assign o_done_cnt = r_done_cnt;
    assign o_err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_dma_cfg_seq.sv
// Scoreboard bench for dma_cfg_seq: expected register writes queued at
// descriptor drive time, popped on each W handshake.
module tb_dma_cfg_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [97:0] desc_msg = '0;
    logic        desc_val = 1'b0;
    logic        desc_rdy;
    logic [43:0] aw_msg;
    logic        aw_val;
    logic        aw_rdy = 1'b1;
    logic [72:0] w_msg;
    logic        w_val;
    logic        w_rdy = 1'b1;
    logic [5:0]  b_msg = '0;
    logic        b_val = 1'b1;
    logic        b_rdy;
    logic [1:0]  done_msg = '0;
    logic        done_val = 1'b0;
    logic        done_rdy;
    logic [3:0]  busy;
    logic [15:0] done_cnt;
    logic [7:0]  err_cnt;

    logic [97:0] x_desc_msg = '0;
    logic        x_desc_val = 1'b0;
    logic        x_desc_rdy, x_aw_val, x_w_val, x_b_rdy, x_done_rdy;
    logic [43:0] x_aw_msg;
    logic [72:0] x_w_msg;
    logic [2:0]  x_busy;
    logic [15:0] x_done_cnt;
    logic [7:0]  x_err_cnt;

    dma_cfg_seq u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_desc_msg(desc_msg), .i_desc_val(desc_val), .o_desc_rdy(desc_rdy),
        .o_aw_msg(aw_msg), .o_aw_val(aw_val), .i_aw_rdy(aw_rdy),
        .o_w_msg(w_msg), .o_w_val(w_val), .i_w_rdy(w_rdy),
        .i_b_msg(b_msg), .i_b_val(b_val), .o_b_rdy(b_rdy),
        .i_done_msg(done_msg), .i_done_val(done_val), .o_done_rdy(done_rdy),
        .o_busy(busy), .o_done_cnt(done_cnt), .o_err_cnt(err_cnt)
    );

    dma_cfg_seq #(.NUM_CH(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_desc_msg(x_desc_msg), .i_desc_val(x_desc_val), .o_desc_rdy(x_desc_rdy),
        .o_aw_msg(x_aw_msg), .o_aw_val(x_aw_val), .i_aw_rdy(1'b1),
        .o_w_msg(x_w_msg), .o_w_val(x_w_val), .i_w_rdy(1'b1),
        .i_b_msg(6'd0), .i_b_val(1'b1), .o_b_rdy(x_b_rdy),
        .i_done_msg(2'd0), .i_done_val(1'b0), .o_done_rdy(x_done_rdy),
        .o_busy(x_busy), .o_done_cnt(x_done_cnt), .o_err_cnt(x_err_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    int n_chk = 0;
    int n_pass = 0;
    int n_aw = 0;
    logic bp_en = 1'b0;
    logic bresp_inj = 1'b0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Slave model and bus monitor share one process so ready and capture agree.
    initial begin
        int aw_stall = 0;
        int w_stall = 0;
        logic aw_hold = 1'b0;
        logic w_hold = 1'b0;
        logic [43:0] aw_prev = '0;
        logic [72:0] w_prev = '0;
        logic [31:0] last_aw = '0;
        logic [31:0] last_w = '0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (bp_en && aw_val && aw_stall < 5) begin
                aw_rdy = 1'b0; aw_stall++;
            end else begin
                aw_rdy = 1'b1; if (aw_val) aw_stall = 0;
            end
            if (bp_en && w_val && w_stall < 5) begin
                w_rdy = 1'b0; w_stall++;
            end else begin
                w_rdy = 1'b1; if (w_val) w_stall = 0;
            end
            b_msg = (bresp_inj && last_w[8:0] == 9'h100) ? 6'h2 : 6'h0;
            if (rst) begin
                aw_hold = 1'b0; w_hold = 1'b0; aw_stall = 0; w_stall = 0;
            end else begin
                if (aw_val || w_val) chk("aw_w_excl", 80'(aw_val && w_val), 80'(0));
                if (aw_hold) chk("aw_stable", {aw_val, aw_msg}, {1'b1, aw_prev});
                if (w_hold) chk("w_stable", {w_val, w_msg}, {1'b1, w_prev});
                aw_hold = aw_val && !aw_rdy;
                w_hold  = w_val && !w_rdy;
                aw_prev = aw_msg;
                w_prev  = w_msg;
                if (aw_val && aw_rdy) begin
                    last_aw = aw_msg[31:0]; n_aw++;
                end
                if (w_val && w_rdy) begin
                    if (q.size() == 0) chk("sb_extra_write", 80'(w_msg), 80'(0));
                    else begin
                        e = q.pop_front();
                        chk("aw_addr", 80'(last_aw), 80'(e.addr));
                        chk("w_data", 80'(w_msg), {7'd0, 8'hFF, 1'b1, 32'd0, e.data});
                    end
                    last_w = last_aw;
                end
            end
        end
    end

    task automatic push(input logic [1:0] ch, input logic [31:0] src, dst, len);
        int n = 0;
        wr_t e;
        if (len != 0) begin
            for (int i = 0; i < 4; i++) begin
                e.addr = 32'(ch) * 32'h200 + 32'(i) * 32'h80;
                e.data = (i == 0) ? src : (i == 1) ? dst : (i == 2) ? len : 32'd1;
                q.push_back(e);
            end
        end
        @(negedge clk);
        desc_val = 1'b1;
        desc_msg = {ch, len, dst, src};
        while (!desc_rdy && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) chk("push_timeout", 80'(desc_rdy), 80'(1));
        @(negedge clk);
        desc_val = 1'b0;
    endtask

    task automatic done(input logic [1:0] ch);
        @(negedge clk);
        done_val = 1'b1;
        done_msg = ch;
        @(negedge clk);
        done_val = 1'b0;
    endtask

    task automatic wait_busy(input logic [3:0] m, input int bound);
        int n = 0;
        while (busy !== m && n < bound) begin
            @(negedge clk); n++;
        end
        chk("busy", 80'(busy), 80'(m));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        repeat (3) @(negedge clk);
        chk("rst_desc_rdy", 80'(desc_rdy), 80'(0));
        chk("rst_vals", {aw_val, w_val, b_rdy}, 80'(0));
        chk("rst_msgs", {aw_msg, w_msg}, 80'(0));
        chk("rst_cnts", {busy, done_cnt, err_cnt}, 80'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("desc_rdy_after_rst", 80'(desc_rdy), 80'(1));

        push(2'd0, 32'h1000, 32'h4000, 32'h3F);
        chk("lat_t1", 80'(aw_val), 80'(0));
        @(negedge clk);
        chk("lat_t2", 80'(aw_val), 80'(1));
        wait_busy(4'b0001, 40);
        chk("sb_drain1", 80'(q.size()), 80'(0));
        done(2'd0);
        wait_busy(4'b0000, 5);
        chk("done_cnt1", 80'(done_cnt), 80'(1));

        push(2'd2, 32'h2222, 32'h5555, 32'h10);
        push(2'd3, 32'h3333, 32'h6666, 32'h20);
        wait_busy(4'b1100, 80);
        done(2'd3);
        wait_busy(4'b0100, 5);
        done(2'd2);
        wait_busy(4'b0000, 5);
        chk("done_cnt2", 80'(done_cnt), 80'(3));

        bp_en = 1'b1;
        push(2'd1, 32'hAAAA, 32'hBBBB, 32'h40);
        wait_busy(4'b0010, 200);
        bp_en = 1'b0;
        chk("sb_drain_bp", 80'(q.size()), 80'(0));
        done(2'd1);
        wait_busy(4'b0000, 5);
        chk("done_cnt_bp", 80'(done_cnt), 80'(4));

        push(2'd0, 32'h10, 32'h20, 32'h8);
        wait_busy(4'b0001, 40);
        for (int k = 1; k <= 4; k++)
            push(2'd0, 32'h100 * k, 32'h7000 + k, 32'h8 + k);
        chk("fifo_full", 80'(desc_rdy), 80'(0));
        fork
            push(2'd0, 32'h500, 32'h7005, 32'hD);
            begin
                repeat (5) @(negedge clk);
                chk("fifo_full_hold", 80'(desc_rdy), 80'(0));
                done(2'd0);
            end
        join
        repeat (5) begin
            wait_busy(4'b0001, 200);
            done(2'd0);
        end
        wait_busy(4'b0000, 20);
        chk("sb_drain_fifo", 80'(q.size()), 80'(0));
        chk("done_cnt_fifo", 80'(done_cnt), 80'(10));

        snap = n_aw;
        push(2'd1, 32'h1, 32'h2, 32'h0);
        repeat (4) @(negedge clk);
        chk("len0_no_aw", 80'(n_aw), 80'(snap));
        chk("len0_done_cnt", 80'(done_cnt), 80'(11));

        done(2'd1);
        chk("spurious_err", 80'(err_cnt), 80'(1));
        chk("spurious_busy", 80'(busy), 80'(0));

        @(negedge clk);
        x_desc_val = 1'b1;
        x_desc_msg = {2'd3, 32'h40, 32'h2000, 32'h1000};
        @(negedge clk);
        x_desc_val = 1'b0;
        repeat (3) @(negedge clk);
        chk("badch_err", 80'(x_err_cnt), 80'(1));
        chk("badch_quiet", {x_aw_val, x_busy, x_done_cnt}, 80'(0));

`ifdef DMA_CFG_SEQ_BRESP_CHECK_EN
        bresp_inj = 1'b1;
        push(2'd0, 32'h9000, 32'h9100, 32'h5);
        void'(q.pop_back());
        repeat (20) @(negedge clk);
        bresp_inj = 1'b0;
        chk("bresp_busy", 80'(busy), 80'(0));
        chk("bresp_err", 80'(err_cnt), 80'(2));
        chk("bresp_no_start", 80'(q.size()), 80'(0));
`endif

        bp_en = 1'b1;
        push(2'd2, 32'hC0, 32'hC1, 32'hC2);
        n = 0;
        while (!w_val && n < 100) begin
            @(negedge clk); n++;
        end
        chk("w_seen", 80'(w_val), 80'(1));
        rst = 1'b1;
        @(negedge clk);
        bp_en = 1'b0;
        q.delete();
        chk("midrst_vals", {aw_val, w_val, b_rdy, desc_rdy}, 80'(0));
        chk("midrst_msgs", {aw_msg, w_msg}, 80'(0));
        chk("midrst_cnts", {busy, done_cnt, err_cnt}, 80'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rdy", 80'(desc_rdy), 80'(1));
        repeat (6) @(negedge clk);
        chk("midrst_no_resume", {aw_val, w_val, busy}, 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
